bird_sprite_engine: RTL
=======================

BIRD_SPRITE_ENGINE -- requirements
Module: bird_sprite_engine

Interface
REQ-001 Parameter SPR_W, 4: sprite width in pixels (1..8).
REQ-002 Parameter SPR_H, 4: sprite height in pixels (1..8).
REQ-003 Parameter SCR_W, 160: screen width; legal X is 0..SCR_W-SPR_W.
REQ-004 Parameter SCR_H, 120: screen height; legal Y is 0..SCR_H-SPR_H.
REQ-005 Parameter STEP, 1: pixels moved per MOVE/FALL/ESCAPE command (1..7).
REQ-006 Parameter COLOUR, 3'b111: sprite draw colour.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 cmd  in  3  opcode: 0 NOP, 1 CLEAR, 2 DRAW, 3 MOVE, 4 FALL, 5 ESCAPE, 6 LOAD, 7 reserved (treated as NOP).
REQ-010 dir  in  2  MOVE direction: bit1 = 1 left / 0 right; bit0 = 1 up / 0 down.
REQ-011 cmd_valid  in  1  command offered.
REQ-012 cmd_ready  out  1  engine accepts a command this cycle.
REQ-013 x_in / y_in  in  8 / 7  LOAD position.
REQ-014 x_player / y_player  in  8 / 7  crosshair position.
REQ-015 firing  in  1  trigger pulled.
REQ-016 x_out / y_out  out  8 / 7  pixel address to VGA.
REQ-017 colour  out  3  pixel colour.
REQ-018 plot  out  1  pixel write strobe.
REQ-019 done  out  1  one-cycle pulse at command completion.
REQ-020 x_pos / y_pos  out  8 / 7  current sprite origin (top-left).
REQ-021 flying  out  1  the last FALL/ESCAPE moved the sprite.
REQ-022 shot  out  1  sticky hit flag.

Function
REQ-023 A command is accepted on a cycle with cmd_valid && cmd_ready; cmd_ready is 1 only in IDLE.
REQ-024 States: IDLE, SWEEP, UPDATE, DONE; IDLE->SWEEP on accepted CLEAR/DRAW; IDLE->UPDATE on accepted MOVE/FALL/ESCAPE/LOAD; SWEEP->DONE after the last pixel; UPDATE->DONE after 1 cycle; DONE->IDLE after 1 cycle.
REQ-025 An accepted NOP or reserved opcode leaves the FSM in IDLE, and done stays 0.
REQ-026 SWEEP emits SPR_W*SPR_H pixels, one per cycle, in raster order: x_out = x_pos+i, y_out = y_pos+j, with i fastest; plot = 1 on every SWEEP cycle only.
REQ-027 colour is 3'b000 for CLEAR and COLOUR for DRAW, and is latched at command acceptance.
REQ-028 Command-to-done latency: CLEAR/DRAW = SPR_W*SPR_H+1 cycles after acceptance; others = 2 cycles.
REQ-029 MOVE adds or subtracts STEP on each axis per dir; each axis saturates independently at 0 and at its limit (REQ-003/004) and never wraps.
REQ-030 FALL: if y_pos < limit, y_pos += min(STEP, limit-y_pos) and flying = 1; else flying = 0 and shot is cleared.
REQ-031 ESCAPE: if y_pos > 0, y_pos -= min(STEP, y_pos) and flying = 1; else flying = 0.
REQ-032 LOAD copies x_in/y_in, each clamped to its limit; shot = 0; flying = 0.
REQ-033 x_pos/y_pos change only in UPDATE, so they are stable throughout a SWEEP.
REQ-034 cmd_valid while not ready is ignored; the command is not queued.

Reset
REQ-035 While reset is high, at the next rising edge: FSM = IDLE, x_pos = 0, y_pos = 0, x_out = 0, y_out = 0, colour = 0, plot = 0, done = 0, flying = 0, shot = 0, sweep counters = 0, cmd_ready = 0 during that cycle and 1 on the following cycle.
REQ-036 Reset during SWEEP aborts it immediately; no further plot pulses occur.

Configuration
REQ-037 With BIRD_HITBOX_EN defined: on every DRAW SWEEP cycle with firing = 1 and x_pos <= x_player <= x_pos+SPR_W-1 and y_pos <= y_player <= y_pos+SPR_H-1, shot is set at the next edge; shot stays set until LOAD, reset, or a FALL at the floor.
REQ-038 Without BIRD_HITBOX_EN: shot is tied to 0, and x_player, y_player and firing are unused.

Verification
REQ-039 Defaults; LOAD (90,80), then DRAW -> 16 plot cycles covering (90..93, 80..83) in raster order, colour 7, done pulses 17 cycles after acceptance.
REQ-040 LOAD (156,0), then MOVE dir=2'b01 (right, up) -> pos stays (156,0); then MOVE dir=2'b10 (left, down) -> pos (155,1).
REQ-041 BIRD_HITBOX_EN defined; pos (10,10), player (13,13), firing = 1, DRAW -> shot = 1; repeat with player (14,13) -> shot stays 0.
REQ-042 pos y = 115, STEP = 3: FALL -> y = 116 and flying = 1; FALL -> y = 116, flying = 0, shot = 0.
REQ-043 Assert reset during the 5th pixel of a DRAW -> plot = 0 from the next edge, all outputs match REQ-035, and cmd_ready = 1 one cycle after reset drops.
REQ-044 SPR_W = 8, SPR_H = 2: CLEAR -> exactly 16 plots, colour 0, done at cycle 17.

Source files
------------

// File: rtl/bird_sprite_engine_if.sv
// rtl/bird_sprite_engine_if.sv - command handshake and pixel output bus for bird_sprite_engine
interface bird_sprite_engine_if;
  logic [2:0] cmd;
  logic [1:0] dir;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;

  modport master (
    output cmd, dir, cmd_valid, x_in, y_in,
    input  cmd_ready, x_out, y_out, colour, plot
  );

  modport slave (
    input  cmd, dir, cmd_valid, x_in, y_in,
    output cmd_ready, x_out, y_out, colour, plot
  );
endinterface

// File: rtl/bird_sprite_engine.sv
// rtl/bird_sprite_engine.sv - duck-hunt style bird sprite: position update and raster sweep to VGA
// Optional hit detection against the player crosshair is enabled with BIRD_HITBOX_EN.
module bird_sprite_engine #(
  parameter int          SPR_W  = 4,
  parameter int          SPR_H  = 4,
  parameter int          SCR_W  = 160,
  parameter int          SCR_H  = 120,
  parameter int          STEP   = 1,
  parameter logic [2:0]  COLOUR = 3'b111
) (
  input  logic                 clk,
  input  logic                 reset,
  bird_sprite_engine_if.slave  bus,
  input  logic [7:0]           x_player,
  input  logic [6:0]           y_player,
  input  logic                 firing,
  output logic                 done,
  output logic [7:0]           x_pos,
  output logic [6:0]           y_pos,
  output logic                 flying,
  output logic                 shot
);
  typedef enum logic [1:0] {IDLE, SWEEP, UPDATE, DONE} state_t;

  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_DRAW   = 3'd2;
  localparam logic [2:0] OP_MOVE   = 3'd3;
  localparam logic [2:0] OP_FALL   = 3'd4;
  localparam logic [2:0] OP_ESCAPE = 3'd5;
  localparam logic [2:0] OP_LOAD   = 3'd6;

  localparam logic [7:0] X_MAX  = 8'(SCR_W - SPR_W);
  localparam logic [6:0] Y_MAX  = 7'(SCR_H - SPR_H);
  localparam logic [2:0] I_LAST = 3'(SPR_W - 1);
  localparam logic [2:0] J_LAST = 3'(SPR_H - 1);
  localparam logic [7:0] STEP_X = 8'(STEP);
  localparam logic [6:0] STEP_Y = 7'(STEP);

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic [1:0] dir_q;
  logic [7:0] x_in_q;
  logic [6:0] y_in_q;
  logic [2:0] i_cnt, j_cnt;
  logic [2:0] colour_q;
  logic       accept;
  logic       sweep_last;
  logic       shot_clr;
  logic [7:0] x_inc, x_dec;
  logic [6:0] y_inc, y_dec;

  assign accept     = bus.cmd_valid && bus.cmd_ready;
  assign sweep_last = (i_cnt == I_LAST) && (j_cnt == J_LAST);

  // Saturating steps; positions never exceed their limit, so the subtractions cannot underflow.
  assign x_inc = ((X_MAX - x_pos) >= STEP_X) ? x_pos + STEP_X : X_MAX;
  assign x_dec = (x_pos >= STEP_X) ? x_pos - STEP_X : 8'd0;
  assign y_inc = ((Y_MAX - y_pos) >= STEP_Y) ? y_pos + STEP_Y : Y_MAX;
  assign y_dec = (y_pos >= STEP_Y) ? y_pos - STEP_Y : 7'd0;

  assign shot_clr = (state == UPDATE) &&
                    ((op_q == OP_LOAD) || ((op_q == OP_FALL) && (y_pos >= Y_MAX)));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.cmd)
            OP_CLEAR, OP_DRAW:                    state_nxt = SWEEP;
            OP_MOVE, OP_FALL, OP_ESCAPE, OP_LOAD: state_nxt = UPDATE;
            default:                              state_nxt = IDLE;
          endcase
        end
      end
      SWEEP:   if (sweep_last) state_nxt = DONE;
      UPDATE:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == IDLE) && !reset;
    bus.plot      = (state == SWEEP);
    bus.x_out     = x_pos + {5'd0, i_cnt};
    bus.y_out     = y_pos + {4'd0, j_cnt};
    bus.colour    = colour_q;
    done          = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= 3'd0;
      dir_q    <= 2'd0;
      x_in_q   <= 8'd0;
      y_in_q   <= 7'd0;
      i_cnt    <= 3'd0;
      j_cnt    <= 3'd0;
      colour_q <= 3'd0;
      x_pos    <= 8'd0;
      y_pos    <= 7'd0;
      flying   <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= bus.cmd;
        dir_q  <= bus.dir;
        x_in_q <= bus.x_in;
        y_in_q <= bus.y_in;
        if (bus.cmd == OP_CLEAR)     colour_q <= 3'b000;
        else if (bus.cmd == OP_DRAW) colour_q <= COLOUR;
      end

      if (state == SWEEP) begin
        if (i_cnt == I_LAST) begin
          i_cnt <= 3'd0;
          j_cnt <= sweep_last ? 3'd0 : j_cnt + 3'd1;
        end else begin
          i_cnt <= i_cnt + 3'd1;
        end
      end

      if (state == UPDATE) begin
        case (op_q)
          OP_MOVE: begin
            x_pos <= dir_q[1] ? x_dec : x_inc;
            y_pos <= dir_q[0] ? y_dec : y_inc;
          end
          OP_FALL: begin
            if (y_pos < Y_MAX) begin
              y_pos  <= y_inc;
              flying <= 1'b1;
            end else begin
              flying <= 1'b0;
            end
          end
          OP_ESCAPE: begin
            if (y_pos > 7'd0) begin
              y_pos  <= y_dec;
              flying <= 1'b1;
            end else begin
              flying <= 1'b0;
            end
          end
          OP_LOAD: begin
            x_pos  <= (x_in_q > X_MAX) ? X_MAX : x_in_q;
            y_pos  <= (y_in_q > Y_MAX) ? Y_MAX : y_in_q;
            flying <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BIRD_HITBOX_EN
  logic hit;

  // Widened compares so a sprite at the right/bottom edge cannot wrap its far bound.
  assign hit = (state == SWEEP) && (op_q == OP_DRAW) && firing &&
               (x_player >= x_pos) && ({1'b0, x_player} <= ({1'b0, x_pos} + 9'(SPR_W - 1))) &&
               (y_player >= y_pos) && ({1'b0, y_player} <= ({1'b0, y_pos} + 8'(SPR_H - 1)));

  always_ff @(posedge clk) begin
    if (reset)         shot <= 1'b0;
    else if (shot_clr) shot <= 1'b0;
    else if (hit)      shot <= 1'b1;
  end
`else
  logic unused_hitbox;
  assign unused_hitbox = ^{x_player, y_player, firing, shot_clr};
  assign shot = 1'b0;
`endif
endmodule
